galois_pow_serial: RTL and testbench
====================================

GALOIS_POW_SERIAL -- requirements
Module: galois_pow_serial

Interface
REQ-001 SHALL have parameter N_BITS, default 254, the field element width.
REQ-002 SHALL have parameter E_BITS, default 254, the exponent width.
REQ-003 SHALL have parameter GALOIS_MULT_METHOD, default "peasant", passed unchanged to the multiplier.
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  in  1  start request, sampled only in IDLE and DONE.
REQ-007 SHALL have port base  in  N_BITS  field element, reduced mod p, captured on start.
REQ-008 SHALL have port exponent  in  E_BITS  unsigned exponent, captured on start.
REQ-009 SHALL have port result  out  N_BITS  base^exponent mod p, registered.
REQ-010 SHALL have port done  out  1  result valid, held high until the next start or reset.

Function
REQ-011 SHALL compute base^exponent mod p by left-to-right square-and-multiply; main use: MiMC decryption with exponent = 7^-1 mod (p-1), the inverse of x^7.
REQ-012 SHALL use states IDLE, SCAN, SQR_A, SQR_B, SQR_C, MUL_A, MUL_B, MUL_C, NEXT, DONE.
REQ-013 SHALL, in IDLE or DONE with en=1, latch base and exponent, clear done, load bit counter to E_BITS-1, and enter SCAN.
REQ-014 SHALL, in SCAN, shift the exponent left one bit per cycle and decrement the counter until the MSB is 1; on the first 1, set acc=base and go to NEXT with no multiply.
REQ-015 SHALL, if the counter expires in SCAN with no 1 found (exponent=0), set result=1 and enter DONE; this holds for base=0 too.
REQ-016 SHALL, in NEXT, go to DONE with result=acc if no bits remain; otherwise shift exponent, decrement counter, and go to SQR_A.
REQ-017 SHALL, in SQR_A, drive num1=num2=acc with multiplier reset high; in SQR_B, release multiplier reset and wait for mult done; in SQR_C, capture acc=product and reassert multiplier reset.
REQ-018 SHALL, after SQR_C, go to MUL_A if the current exponent MSB is 1, else to NEXT.
REQ-019 SHALL run MUL_A/B/C the same way as SQR_A/B/C with num1=acc and num2=latched base, then go to NEXT.
REQ-020 SHALL hold the multiplier in reset for at least one cycle between consecutive products.
REQ-021 SHALL ignore en in every state except IDLE and DONE; base and exponent SHALL NOT be resampled mid-operation.
REQ-022 SHALL give latency from start to done = (E_BITS - k) SCAN cycles + (k-1) NEXT cycles + per-product (2 + T_mult + 1) cycles + 2, where k = bit length of the exponent.
REQ-023 SHALL hold result stable from DONE until the next start accepts; en=1 in DONE restarts immediately, and done SHALL drop the cycle after the start.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE, set done=0, result=0, and hold the multiplier in reset, regardless of the current state.
REQ-025 SHALL abandon any operation in progress on mid-operation reset; the first start after reset SHALL produce a correct result.

Structure
REQ-026 SHALL take modulus p, N_BITS default, and constant MIMC_INV7_EXP (7^-1 mod (p-1)) from the shared galois package.
REQ-027 SHALL instantiate exactly one galois_mult sub-module (ports clk, rst, en, num1, num2, product, done) with en tied high.
REQ-028 SHALL declare the state encoding as localparams local to this module.

Verification
REQ-029 SHALL cover: base=2, exponent=7 -> result=128, done held high.
REQ-030 SHALL cover: base=3, exponent=0 -> result=1; base=0, exponent=0 -> result=1; base=0, exponent=5 -> result=0.
REQ-031 SHALL cover: base=5, exponent=1 -> result=5 with zero multiplier runs; base=p-1, exponent=2 -> result=1.
REQ-032 SHALL cover round trip: x=12345 with exponent=7 gives y; y with exponent=MIMC_INV7_EXP gives 12345.
REQ-033 SHALL cover: rst pulsed during MUL_B of a run -> done=0 and result=0 next cycle; a following start with base=2, exponent=10 -> result=1024.
REQ-034 SHALL cover: en toggled during a run -> no effect; en=1 held in DONE -> back-to-back runs with a correct result each time.

Source files
------------

// File: rtl/galois_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | galois_pkg                                                           |
// | Shared prime-field constants: BN254 scalar modulus and MiMC inverse  |
// | exponent 7^-1 mod (p-1).                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package galois_pkg;

    localparam int N_BITS_DEFAULT = 254;
    localparam int INV_W          = N_BITS_DEFAULT + 4;

    localparam logic [N_BITS_DEFAULT-1:0] P =
        254'd21888242871839275222246405745257275088548364400416034343698204186575808495617;

    // Exactly one m in 1..6 makes m*(p-1)+1 divisible by 7; the quotient is the inverse.
    function automatic logic [N_BITS_DEFAULT-1:0] calc_inv7_exp();
        logic [INV_W-1:0]          t;
        logic [N_BITS_DEFAULT-1:0] r;
        r = '0;
        for (int m = 1; m <= 6; m++) begin
            t = INV_W'(P - N_BITS_DEFAULT'(1)) * INV_W'(m) + INV_W'(1);
            if ((t % INV_W'(7)) == '0) begin
                r = N_BITS_DEFAULT'(t / INV_W'(7));
            end
        end
        return r;
    endfunction

    localparam logic [N_BITS_DEFAULT-1:0] MIMC_INV7_EXP = calc_inv7_exp();

endpackage : galois_pkg
`default_nettype wire

// File: rtl/galois_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | galois_mult                                                          |
// | Modular multiplier mod p; starts when rst drops, raises done once.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module galois_mult
    import galois_pkg::*;
#(
    parameter int    N_BITS             = N_BITS_DEFAULT,
    parameter string GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] num1,
    input  logic [N_BITS-1:0] num2,
    output logic [N_BITS-1:0] product,
    output logic              done
);

    localparam logic [N_BITS-1:0] MOD = N_BITS'(P);

    generate
        if (GALOIS_MULT_METHOD == "direct") begin : g_direct
            logic [N_BITS-1:0] w_mod;
            logic [N_BITS-1:0] r_prod;
            logic              r_done;

            assign w_mod = N_BITS'(({{N_BITS{1'b0}}, num1} * {{N_BITS{1'b0}}, num2})
                                   % {{N_BITS{1'b0}}, MOD});

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prod <= '0;
                    r_done <= 1'b0;
                end else if (en && !r_done) begin
                    r_prod <= w_mod;
                    r_done <= 1'b1;
                end
            end

            assign product = r_prod;
            assign done    = r_done;
        end else begin : g_peasant
            // Operands are loaded while held in reset; num2 is consumed LSB first
            // and the product is ready one cycle after its last set bit.
            logic [N_BITS-1:0] r_a;
            logic [N_BITS-1:0] r_b;
            logic [N_BITS-1:0] r_acc;
            logic              r_done;
            logic [N_BITS:0]   w_sum;
            logic [N_BITS:0]   w_dbl;
            logic [N_BITS-1:0] w_sum_red;
            logic [N_BITS-1:0] w_dbl_red;

            assign w_sum     = {1'b0, r_acc} + {1'b0, r_a};
            assign w_dbl     = {r_a, 1'b0};
            assign w_sum_red = (w_sum >= {1'b0, MOD}) ? N_BITS'(w_sum - {1'b0, MOD})
                                                      : w_sum[N_BITS-1:0];
            assign w_dbl_red = (w_dbl >= {1'b0, MOD}) ? N_BITS'(w_dbl - {1'b0, MOD})
                                                      : w_dbl[N_BITS-1:0];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a    <= num1;
                    r_b    <= num2;
                    r_acc  <= '0;
                    r_done <= 1'b0;
                end else if (en && !r_done) begin
                    if (r_b == '0) begin
                        r_done <= 1'b1;
                    end else begin
                        if (r_b[0]) begin
                            r_acc <= w_sum_red;
                        end
                        r_a <= w_dbl_red;
                        r_b <= r_b >> 1;
                    end
                end
            end

            assign product = r_acc;
            assign done    = r_done;
        end
    endgenerate

endmodule : galois_mult
`default_nettype wire

// File: rtl/galois_pow_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | galois_pow_serial                                                    |
// | Serial left-to-right square-and-multiply: result = base^exp mod p.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module galois_pow_serial
    import galois_pkg::*;
#(
    parameter int    N_BITS             = N_BITS_DEFAULT,
    parameter int    E_BITS             = 254,
    parameter string GALOIS_MULT_METHOD = "peasant"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_BITS-1:0] base,
    input  logic [E_BITS-1:0] exponent,
    output logic [N_BITS-1:0] result,
    output logic              done
);

    localparam int CNT_W = (E_BITS > 1) ? $clog2(E_BITS) : 1;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] SCAN  = 4'd1;
    localparam logic [3:0] SQR_A = 4'd2;
    localparam logic [3:0] SQR_B = 4'd3;
    localparam logic [3:0] SQR_C = 4'd4;
    localparam logic [3:0] MUL_A = 4'd5;
    localparam logic [3:0] MUL_B = 4'd6;
    localparam logic [3:0] MUL_C = 4'd7;
    localparam logic [3:0] NEXT  = 4'd8;
    localparam logic [3:0] DONE  = 4'd9;

    localparam logic [N_BITS-1:0] ONE = N_BITS'(1);

    logic [3:0]        r_state;
    logic [N_BITS-1:0] r_base;
    logic [E_BITS-1:0] r_exp;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_BITS-1:0] r_acc;
    logic [N_BITS-1:0] r_result;
    logic              r_done;

    logic              w_mult_rst;
    logic              w_mult_done;
    logic              w_is_mul;
    logic [N_BITS-1:0] w_num2;
    logic [N_BITS-1:0] w_product;

    // The multiplier only runs in the B states, so it sits in reset for the
    // A/C cycles around every product and whenever the block is idle.
    assign w_mult_rst = rst || !((r_state == SQR_B) || (r_state == MUL_B));
    assign w_is_mul   = (r_state == MUL_A) || (r_state == MUL_B) || (r_state == MUL_C);
    assign w_num2     = w_is_mul ? r_base : r_acc;

    galois_mult #(
        .N_BITS             (N_BITS),
        .GALOIS_MULT_METHOD (GALOIS_MULT_METHOD)
    ) u_mult (
        .clk     (clk),
        .rst     (w_mult_rst),
        .en      (1'b1),
        .num1    (r_acc),
        .num2    (w_num2),
        .product (w_product),
        .done    (w_mult_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_exp    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (en) begin
                        r_base  <= base;
                        r_exp   <= exponent;
                        r_cnt   <= CNT_W'(E_BITS - 1);
                        r_done  <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_exp[E_BITS-1]) begin
                        r_acc   <= r_base;
                        r_state <= NEXT;
                    end else if (r_cnt == '0) begin
                        r_result <= ONE;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_exp <= r_exp << 1;
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                NEXT: begin
                    if (r_cnt == '0) begin
                        r_result <= r_acc;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_exp   <= r_exp << 1;
                        r_cnt   <= r_cnt - CNT_W'(1);
                        r_state <= SQR_A;
                    end
                end
                SQR_A: r_state <= SQR_B;
                SQR_B: begin
                    if (w_mult_done) begin
                        r_state <= SQR_C;
                    end
                end
                SQR_C: begin
                    r_acc   <= w_product;
                    r_state <= r_exp[E_BITS-1] ? MUL_A : NEXT;
                end
                MUL_A: r_state <= MUL_B;
                MUL_B: begin
                    if (w_mult_done) begin
                        r_state <= MUL_C;
                    end
                end
                MUL_C: begin
                    r_acc   <= w_product;
                    r_state <= NEXT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;

endmodule : galois_pow_serial
`default_nettype wire

// File: tb/tb_galois_pow_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_galois_pow_serial                                                 |
// | Self-checking bench against a right-to-left modpow reference model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_galois_pow_serial;
    import galois_pkg::*;

    localparam int NB      = 254;
    localparam int EB      = 254;
    localparam int TIMEOUT = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [NB-1:0] base;
    logic [EB-1:0] exponent;
    logic [NB-1:0] result;
    logic          done;

    logic          f_en;
    logic [NB-1:0] f_base;
    logic [EB-1:0] f_exponent;
    logic [NB-1:0] f_result;
    logic          f_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    galois_pow_serial dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .base     (base),
        .exponent (exponent),
        .result   (result),
        .done     (done)
    );

    // Single-cycle multiplier variant keeps the full-width round trip short.
    galois_pow_serial #(
        .GALOIS_MULT_METHOD ("direct")
    ) dut_fast (
        .clk      (clk),
        .rst      (rst),
        .en       (f_en),
        .base     (f_base),
        .exponent (f_exponent),
        .result   (f_result),
        .done     (f_done)
    );

    task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] ref_pow(input logic [NB-1:0] b, input logic [EB-1:0] e);
        logic [2*NB-1:0] r;
        logic [2*NB-1:0] x;
        logic [2*NB-1:0] m;
        m = {{NB{1'b0}}, P};
        r = 1;
        x = {{NB{1'b0}}, b};
        for (int i = 0; i < EB; i++) begin
            if (e[i]) r = (r * x) % m;
            x = (x * x) % m;
        end
        return r[NB-1:0];
    endfunction

    function automatic logic [NB-1:0] rand_elem();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom();
        return NB'(w % {2'b00, P});
    endfunction

    task automatic wait_done(input string tag);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!done && cnt < TIMEOUT);
        check({tag, "_timeout"}, NB'(done), NB'(1));
    endtask

    task automatic wait_fdone(input string tag);
        int cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!f_done && cnt < TIMEOUT);
        check({tag, "_timeout"}, NB'(f_done), NB'(1));
    endtask

    // One start pulse, optional en/input noise while busy; lat counts edges after start.
    task automatic run(input string tag, input logic [NB-1:0] b, input logic [EB-1:0] e,
                       input bit wiggle, output logic [NB-1:0] res, output int lat);
        @(negedge clk);
        base = b; exponent = e; en = 1'b1;
        @(negedge clk);
        en = 1'b0; base = rand_elem(); exponent = EB'(rand_elem());
        check({tag, "_done_drop"}, NB'(done), NB'(0));
        lat = 0;
        while (!done && lat < TIMEOUT) begin
            if (wiggle) begin
                en       = 1'($urandom_range(0, 1));
                base     = rand_elem();
                exponent = EB'(rand_elem());
            end
            @(negedge clk);
            lat++;
        end
        en = 1'b0;
        check({tag, "_timeout"}, NB'(done), NB'(1));
        res = result;
    endtask

    initial begin
        logic [NB-1:0]   res;
        logic [NB-1:0]   y;
        logic [NB-1:0]   rb;
        logic [EB-1:0]   re;
        logic [2*NB-1:0] inv_chk;
        int              lat;

        rst = 1'b1; en = 1'b0; base = '0; exponent = '0;
        f_en = 1'b0; f_base = '0; f_exponent = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, '0);
        check("rst_done", NB'(done), NB'(0));
        check("rst_fdone", NB'(f_done), NB'(0));
        rst = 1'b0;

        inv_chk = ({{NB{1'b0}}, MIMC_INV7_EXP} * (2*NB)'(7)) % {{NB{1'b0}}, P - NB'(1)};
        check("inv7_const", inv_chk[NB-1:0], NB'(1));

        run("pow_2_7", NB'(2), EB'(7), 1'b0, res, lat);
        check("pow_2_7", res, NB'(128));
        repeat (5) @(negedge clk);
        check("hold_done", NB'(done), NB'(1));
        check("hold_result", result, NB'(128));

        run("pow_3_0", NB'(3), EB'(0), 1'b0, res, lat);
        check("pow_3_0", res, NB'(1));
        run("pow_0_0", NB'(0), EB'(0), 1'b0, res, lat);
        check("pow_0_0", res, NB'(1));
        run("pow_0_5", NB'(0), EB'(5), 1'b0, res, lat);
        check("pow_0_5", res, NB'(0));

        run("pow_5_1", NB'(5), EB'(1), 1'b0, res, lat);
        check("pow_5_1", res, NB'(5));
        // Exponent 1: 253 shifting SCAN cycles + found + final NEXT, no products.
        check("lat_5_1", NB'(lat), NB'(255));

        run("pow_pm1_2", P - NB'(1), EB'(2), 1'b0, res, lat);
        check("pow_pm1_2", res, NB'(1));

        // Base p-1 makes the multiply-by-base product ~256 cycles; edge 640
        // after start lands well inside that MUL_B window for exponent 3.
        @(negedge clk);
        base = P - NB'(1); exponent = EB'(3); en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (639) @(negedge clk);
        check("busy_before_rst", NB'(done), NB'(0));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_done", NB'(done), NB'(0));
        check("midrst_result", result, '0);
        rst = 1'b0;
        run("pow_2_10", NB'(2), EB'(10), 1'b0, res, lat);
        check("pow_2_10", res, NB'(1024));

        for (int i = 0; i < 6; i++) begin
            rb = rand_elem();
            re = EB'($urandom_range(1, 4095));
            run("rand", rb, re, 1'b1, res, lat);
            check("rand", res, ref_pow(rb, re));
        end

        // en held high across DONE: restart takes the inputs present in DONE.
        @(negedge clk);
        base = NB'(3); exponent = EB'(5); en = 1'b1;
        wait_done("b2b_1");
        check("b2b_1", result, NB'(243));
        base = NB'(7); exponent = EB'(3);
        @(negedge clk);
        check("b2b_drop", NB'(done), NB'(0));
        en = 1'b0;
        wait_done("b2b_2");
        check("b2b_2", result, NB'(343));

        @(negedge clk);
        f_base = NB'(12345); f_exponent = EB'(7); f_en = 1'b1;
        @(negedge clk);
        f_en = 1'b0;
        wait_fdone("rt_fwd");
        y = f_result;
        check("rt_fwd", y, ref_pow(NB'(12345), EB'(7)));
        f_base = y; f_exponent = EB'(MIMC_INV7_EXP); f_en = 1'b1;
        @(negedge clk);
        f_en = 1'b0;
        wait_fdone("rt_inv");
        check("rt_inv", f_result, NB'(12345));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_galois_pow_serial
`default_nettype wire
